// File: rtl/router_reg.sv
// ---------------------------------------------------------------------------
// router_reg
//   Datapath register stage of the 1x3 router. Sits between the router FSM and
//   the three output FIFOs. It turns the FSM state strobes into the byte that
//   is written to the selected FIFO. It keeps the header across the
//   DECODE_ADDRESS -> LOAD_FIRST_DATA hand-off and parks one byte while the
//   FIFO is full. It also tracks packet parity and reports completion and
//   errors back to the FSM.
//
// Ports
//   clock         rising-edge system clock
//   reset         asynchronous, active-high reset
//   pkt_valid     source packet-valid (low on the parity byte)
//   data_in       source byte; header address in [1:0]
//   fifo_full     full flag of the selected output FIFO
//   detect_add    FSM strobe: DECODE_ADDRESS
//   lfd_state     FSM strobe: LOAD_FIRST_DATA
//   ld_state      FSM strobe: LOAD_DATA
//   full_state    FSM strobe: FIFO_FULL_STATE
//   laf_state     FSM strobe: LOAD_AFTER_FULL
//   rst_int_reg   FSM strobe: CHECK_PARITY_ERROR
//   dout          registered byte to the output FIFOs
//   parity_done   parity byte captured, packet complete
//   low_pkt_valid pkt_valid fell during LOAD_DATA
//   err           parity mismatch for the current packet
// ---------------------------------------------------------------------------
module router_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             pkt_valid,
    input  logic [WIDTH-1:0] data_in,
    input  logic             fifo_full,
    input  logic             detect_add,
    input  logic             lfd_state,
    input  logic             ld_state,
    input  logic             full_state,
    input  logic             laf_state,
    input  logic             rst_int_reg,
    output logic [WIDTH-1:0] dout,
    output logic             parity_done,
    output logic             low_pkt_valid,
    output logic             err
);

    // Internal state
    logic [WIDTH-1:0] hold_header;
    logic [WIDTH-1:0] full_byte;
    logic [WIDTH-1:0] internal_parity;
    logic [WIDTH-1:0] packet_parity;

    // Next-state values
    logic [WIDTH-1:0] hold_header_nxt;
    logic [WIDTH-1:0] dout_nxt;
    logic [WIDTH-1:0] full_byte_nxt;
    logic [WIDTH-1:0] internal_parity_nxt;
    logic [WIDTH-1:0] packet_parity_nxt;
    logic             low_pkt_valid_nxt;
    logic             parity_done_nxt;
    logic             err_nxt;

    // Qualified strobes
    logic hdr_load;
    logic parity_byte;

    // Address 2'b11 is not a valid destination. Such a header never reaches
    // hold_header.
    assign hdr_load    = detect_add && pkt_valid && (data_in[1:0] != 2'b11);
    // The parity byte is the LOAD_DATA byte that arrives with pkt_valid low.
    assign parity_byte = ld_state && !pkt_valid;

    // -----------------------------------------------------------------------
    // Header capture
    // -----------------------------------------------------------------------
    always_comb begin
        hold_header_nxt = hold_header;
        if (hdr_load)
            hold_header_nxt = data_in;
    end

    // -----------------------------------------------------------------------
    // Output byte / park register
    // A byte that arrives while the FIFO is full goes to full_byte instead of
    // dout. LOAD_AFTER_FULL then replays it. In FIFO_FULL_STATE both registers
    // are frozen.
    // -----------------------------------------------------------------------
    always_comb begin
        dout_nxt      = dout;
        full_byte_nxt = full_byte;
        if (lfd_state)
            dout_nxt = hold_header;
        else if (ld_state && !fifo_full)
            dout_nxt = data_in;
        else if (ld_state)
            full_byte_nxt = data_in;
        else if (laf_state)
            dout_nxt = full_byte;
        else if (full_state) begin
            dout_nxt      = dout;
            full_byte_nxt = full_byte;
        end
    end

    // -----------------------------------------------------------------------
    // Parity tracking
    // A payload byte is folded in when it is accepted in LOAD_DATA, even if
    // it is being parked. LOAD_AFTER_FULL only replays the byte, so the byte
    // is counted once.
    // -----------------------------------------------------------------------
    always_comb begin
        internal_parity_nxt = internal_parity;
        if (detect_add)
            internal_parity_nxt = '0;
        else if (lfd_state)
            internal_parity_nxt = internal_parity ^ hold_header;
        else if (ld_state && pkt_valid)
            internal_parity_nxt = internal_parity ^ data_in;
    end

    always_comb begin
        packet_parity_nxt = packet_parity;
        if (detect_add)
            packet_parity_nxt = '0;
        else if (parity_byte)
            packet_parity_nxt = data_in;
    end

    // -----------------------------------------------------------------------
    // Status flags back to the FSM
    // -----------------------------------------------------------------------
    always_comb begin
        low_pkt_valid_nxt = low_pkt_valid;
        if (rst_int_reg)
            low_pkt_valid_nxt = 1'b0;
        else if (parity_byte)
            low_pkt_valid_nxt = 1'b1;
    end

    // If the parity byte was parked, the packet is not complete until
    // LOAD_AFTER_FULL has pushed that byte out.
    always_comb begin
        parity_done_nxt = parity_done;
        if (detect_add)
            parity_done_nxt = 1'b0;
        else if ((parity_byte && !fifo_full) ||
                 (laf_state && low_pkt_valid && !parity_done))
            parity_done_nxt = 1'b1;
    end

    // The compare runs one cycle after parity_done. At that point both
    // parity registers are settled. err then stays set until the next
    // packet starts loading.
    always_comb begin
        err_nxt = err;
        if (lfd_state)
            err_nxt = 1'b0;
        else if (parity_done && (internal_parity != packet_parity))
            err_nxt = 1'b1;
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hold_header     <= '0;
            full_byte       <= '0;
            internal_parity <= '0;
            packet_parity   <= '0;
            dout            <= '0;
            parity_done     <= 1'b0;
            low_pkt_valid   <= 1'b0;
            err             <= 1'b0;
        end else begin
            hold_header     <= hold_header_nxt;
            full_byte       <= full_byte_nxt;
            internal_parity <= internal_parity_nxt;
            packet_parity   <= packet_parity_nxt;
            dout            <= dout_nxt;
            parity_done     <= parity_done_nxt;
            low_pkt_valid   <= low_pkt_valid_nxt;
            err             <= err_nxt;
        end
    end

endmodule

// File: tb/tb_router_reg.sv
// ---------------------------------------------------------------------------
// tb_router_reg
//   Bench for router_reg. The stimulus rows mimic the FSM strobe sequence.
//   Each byte accepted as part of a packet goes into a scoreboard queue. The
//   queue is popped whenever the strobes say the byte should appear on dout.
// ---------------------------------------------------------------------------
module tb_router_reg;

    logic       clock;
    logic       reset;
    logic       pkt_valid;
    logic [7:0] data_in;
    logic       fifo_full;
    logic       detect_add;
    logic       lfd_state;
    logic       ld_state;
    logic       full_state;
    logic       laf_state;
    logic       rst_int_reg;
    logic [7:0] dout;
    logic       parity_done;
    logic       low_pkt_valid;
    logic       err;

    router_reg #(.WIDTH(8)) dut (
        .clock         (clock),
        .reset         (reset),
        .pkt_valid     (pkt_valid),
        .data_in       (data_in),
        .fifo_full     (fifo_full),
        .detect_add    (detect_add),
        .lfd_state     (lfd_state),
        .ld_state      (ld_state),
        .full_state    (full_state),
        .laf_state     (laf_state),
        .rst_int_reg   (rst_int_reg),
        .dout          (dout),
        .parity_done   (parity_done),
        .low_pkt_valid (low_pkt_valid),
        .err           (err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef enum logic [2:0] {K_IDLE, K_DA, K_LFD, K_LD, K_FS, K_LAF, K_RIR} kind_e;
    typedef struct {
        kind_e      k;
        logic [7:0] din;
        logic       pv;
        logic       ff;
    } cyc_t;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] exp_q[$];
    logic       emit;
    logic [7:0] e;

    function automatic cyc_t mk(kind_e k, logic [7:0] d, logic pv, logic ff);
        cyc_t c;
        c.k = k; c.din = d; c.pv = pv; c.ff = ff;
        return c;
    endfunction

    // Drive one cycle of strobes. Bytes the packet accepts are pushed to the
    // scoreboard. emit marks a cycle after which dout carries the next one.
    task automatic drive(input cyc_t c);
        pkt_valid   = c.pv;
        data_in     = c.din;
        fifo_full   = c.ff;
        detect_add  = (c.k == K_DA);
        lfd_state   = (c.k == K_LFD);
        ld_state    = (c.k == K_LD);
        full_state  = (c.k == K_FS);
        laf_state   = (c.k == K_LAF);
        rst_int_reg = (c.k == K_RIR);
        if ((c.k == K_DA && c.pv && c.din[1:0] != 2'b11) || c.k == K_LD)
            exp_q.push_back(c.din);
        emit = (c.k == K_LFD) || (c.k == K_LD && !c.ff) || (c.k == K_LAF);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // -----------------------------------------------------------------------
    task automatic test_reset();
        reset = 1'b1;
        drive(mk(K_IDLE, 8'h00, 1'b0, 1'b0));
        tick(); tick();
        n_tests++;
        if ({dout, parity_done, low_pkt_valid, err} !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got dout=%h pd=%b low=%b err=%b, want all 0",
                     dout, parity_done, low_pkt_valid, err);
        end
        n_tests++;
        if ({dut.hold_header, dut.full_byte, dut.internal_parity, dut.packet_parity} !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_internal: got hh=%h fb=%h ip=%h pp=%h, want 0",
                     dut.hold_header, dut.full_byte, dut.internal_parity, dut.packet_parity);
        end
        reset = 1'b0;
    endtask

    // -----------------------------------------------------------------------
    task automatic test_good_packet();
        cyc_t rows[$];
        rows = '{mk(K_DA, 8'h0D, 1, 0), mk(K_LFD, 8'h11, 1, 0), mk(K_LD, 8'h11, 1, 0),
                 mk(K_LD, 8'h22, 1, 0), mk(K_LD, 8'h33, 1, 0), mk(K_LD, 8'h0D, 0, 0),
                 mk(K_RIR, 8'h00, 0, 0)};
        foreach (rows[i]) begin
            drive(rows[i]); tick();
            if (emit) begin
                n_tests++;
                if (exp_q.size() == 0) begin n_fail++; $display("FAIL good_dout[%0d]: got %h, scoreboard empty", i, dout); end
                else begin e = exp_q.pop_front();
                    if (dout !== e) begin n_fail++; $display("FAIL good_dout[%0d]: got %h want %h", i, dout, e); end end
            end
            if (i == 4) begin n_tests++;
                if (parity_done !== 1'b0) begin n_fail++; $display("FAIL good_pd_early: got %b want 0", parity_done); end end
            if (i == 5) begin n_tests++;
                if ({parity_done, low_pkt_valid, err} !== 3'b110) begin n_fail++;
                    $display("FAIL good_flags: got pd/low/err=%b%b%b want 110", parity_done, low_pkt_valid, err); end end
            if (i == 6) begin n_tests++;
                if ({parity_done, low_pkt_valid, err} !== 3'b100) begin n_fail++;
                    $display("FAIL good_after_rir: got pd/low/err=%b%b%b want 100", parity_done, low_pkt_valid, err); end end
        end
    endtask

    // -----------------------------------------------------------------------
    task automatic test_bad_parity();
        cyc_t rows[$];
        rows = '{mk(K_DA, 8'h0D, 1, 0), mk(K_LFD, 8'h11, 1, 0), mk(K_LD, 8'h11, 1, 0),
                 mk(K_LD, 8'h22, 1, 0), mk(K_LD, 8'h33, 1, 0), mk(K_LD, 8'h00, 0, 0),
                 mk(K_RIR, 8'h00, 0, 0), mk(K_IDLE, 8'h00, 0, 0)};
        foreach (rows[i]) begin
            drive(rows[i]); tick();
            if (emit) begin
                n_tests++;
                if (exp_q.size() == 0) begin n_fail++; $display("FAIL bad_dout[%0d]: got %h, scoreboard empty", i, dout); end
                else begin e = exp_q.pop_front();
                    if (dout !== e) begin n_fail++; $display("FAIL bad_dout[%0d]: got %h want %h", i, dout, e); end end
            end
            if (i == 5) begin n_tests++;
                if ({parity_done, err} !== 2'b10) begin n_fail++;
                    $display("FAIL bad_pd_cycle: got pd/err=%b%b want 10", parity_done, err); end end
            if (i >= 6) begin n_tests++;
                if (err !== 1'b1) begin n_fail++; $display("FAIL bad_err[%0d]: got %b want 1", i, err); end end
        end
    endtask

    // -----------------------------------------------------------------------
    // Good packet straight after the bad one. err must survive DECODE_ADDRESS.
    task automatic test_back_to_back();
        cyc_t rows[$];
        rows = '{mk(K_DA, 8'h0D, 1, 0), mk(K_LFD, 8'h11, 1, 0), mk(K_LD, 8'h11, 1, 0),
                 mk(K_LD, 8'h22, 1, 0), mk(K_LD, 8'h33, 1, 0), mk(K_LD, 8'h0D, 0, 0),
                 mk(K_RIR, 8'h00, 0, 0)};
        foreach (rows[i]) begin
            drive(rows[i]); tick();
            if (emit) begin
                n_tests++;
                if (exp_q.size() == 0) begin n_fail++; $display("FAIL b2b_dout[%0d]: got %h, scoreboard empty", i, dout); end
                else begin e = exp_q.pop_front();
                    if (dout !== e) begin n_fail++; $display("FAIL b2b_dout[%0d]: got %h want %h", i, dout, e); end end
            end
            if (i == 0) begin n_tests++;
                if ({err, parity_done, dut.internal_parity, dut.packet_parity} !== 18'h20000) begin n_fail++;
                    $display("FAIL b2b_decode: got err=%b pd=%b ip=%h pp=%h want err=1 pd=0 ip=00 pp=00",
                             err, parity_done, dut.internal_parity, dut.packet_parity); end end
            if (i == 1 || i == 6) begin n_tests++;
                if (err !== 1'b0) begin n_fail++; $display("FAIL b2b_err[%0d]: got %b want 0", i, err); end end
        end
    endtask

    // -----------------------------------------------------------------------
    task automatic test_stall_payload();
        cyc_t rows[$];
        rows = '{mk(K_DA, 8'h0D, 1, 0), mk(K_LFD, 8'h11, 1, 0), mk(K_LD, 8'h11, 1, 0),
                 mk(K_LD, 8'h22, 1, 1), mk(K_FS, 8'h22, 1, 1), mk(K_LAF, 8'h33, 1, 0),
                 mk(K_LD, 8'h33, 1, 0), mk(K_LD, 8'h0D, 0, 0), mk(K_RIR, 8'h00, 0, 0)};
        foreach (rows[i]) begin
            drive(rows[i]); tick();
            if (emit) begin
                n_tests++;
                if (exp_q.size() == 0) begin n_fail++; $display("FAIL stall_dout[%0d]: got %h, scoreboard empty", i, dout); end
                else begin e = exp_q.pop_front();
                    if (dout !== e) begin n_fail++; $display("FAIL stall_dout[%0d]: got %h want %h", i, dout, e); end end
            end
            if (i == 3 || i == 4) begin n_tests++;
                if ({dout, dut.full_byte, dut.internal_parity} !== 24'h11223E) begin n_fail++;
                    $display("FAIL stall_frozen[%0d]: got dout=%h fb=%h ip=%h want 11 22 3e",
                             i, dout, dut.full_byte, dut.internal_parity); end end
            if (i == 7) begin n_tests++;
                if ({dut.internal_parity, parity_done} !== 9'h1B) begin n_fail++;
                    $display("FAIL stall_parity: got ip=%h pd=%b want 0d 1", dut.internal_parity, parity_done); end end
            if (i == 8) begin n_tests++;
                if (err !== 1'b0) begin n_fail++; $display("FAIL stall_err: got %b want 0", err); end end
        end
    endtask

    // -----------------------------------------------------------------------
    task automatic test_stall_parity();
        cyc_t rows[$];
        rows = '{mk(K_DA, 8'h0D, 1, 0), mk(K_LFD, 8'h11, 1, 0), mk(K_LD, 8'h11, 1, 0),
                 mk(K_LD, 8'h22, 1, 0), mk(K_LD, 8'h33, 1, 0), mk(K_LD, 8'h0D, 0, 1),
                 mk(K_FS, 8'h0D, 0, 1), mk(K_LAF, 8'h00, 0, 0), mk(K_RIR, 8'h00, 0, 0)};
        foreach (rows[i]) begin
            drive(rows[i]); tick();
            if (emit) begin
                n_tests++;
                if (exp_q.size() == 0) begin n_fail++; $display("FAIL pstall_dout[%0d]: got %h, scoreboard empty", i, dout); end
                else begin e = exp_q.pop_front();
                    if (dout !== e) begin n_fail++; $display("FAIL pstall_dout[%0d]: got %h want %h", i, dout, e); end end
            end
            if (i == 5 || i == 6) begin n_tests++;
                if ({low_pkt_valid, parity_done, dout, dut.full_byte} !== 18'h2330D) begin n_fail++;
                    $display("FAIL pstall_parked[%0d]: got low=%b pd=%b dout=%h fb=%h want 1 0 33 0d",
                             i, low_pkt_valid, parity_done, dout, dut.full_byte); end end
            if (i == 7) begin n_tests++;
                if (parity_done !== 1'b1) begin n_fail++; $display("FAIL pstall_pd: got %b want 1", parity_done); end end
            if (i == 8) begin n_tests++;
                if ({err, low_pkt_valid} !== 2'b00) begin n_fail++;
                    $display("FAIL pstall_err: got err/low=%b%b want 00", err, low_pkt_valid); end end
        end
    endtask

    // -----------------------------------------------------------------------
    task automatic test_invalid_addr();
        drive(mk(K_DA, 8'h07, 1, 0)); tick();
        n_tests++;
        if (dut.hold_header !== 8'h0D) begin n_fail++;
            $display("FAIL invalid_addr_hold: got %h want 0d", dut.hold_header); end
        n_tests++;
        if ({parity_done, dut.internal_parity} !== 9'h000) begin n_fail++;
            $display("FAIL invalid_addr_clear: got pd=%b ip=%h want 0 00", parity_done, dut.internal_parity); end
        drive(mk(K_IDLE, 8'h00, 0, 0)); tick();
        n_tests++;
        if (exp_q.size() != 0) begin n_fail++;
            $display("FAIL invalid_addr_queue: got %0d entries want 0", exp_q.size()); end
    endtask

    // -----------------------------------------------------------------------
    task automatic test_async_reset();
        cyc_t rows[$];
        rows = '{mk(K_DA, 8'h0D, 1, 0), mk(K_LFD, 8'h11, 1, 0), mk(K_LD, 8'h11, 1, 0),
                 mk(K_LD, 8'h22, 1, 0), mk(K_LD, 8'h33, 1, 0), mk(K_LD, 8'h5A, 0, 0),
                 mk(K_IDLE, 8'h00, 0, 0)};
        foreach (rows[i]) begin
            drive(rows[i]); tick();
            if (emit) begin
                n_tests++;
                if (exp_q.size() == 0) begin n_fail++; $display("FAIL areset_dout[%0d]: got %h, scoreboard empty", i, dout); end
                else begin e = exp_q.pop_front();
                    if (dout !== e) begin n_fail++; $display("FAIL areset_dout[%0d]: got %h want %h", i, dout, e); end end
            end
        end
        n_tests++;
        if ({dout, parity_done, low_pkt_valid, err} !== 11'h2D7) begin n_fail++;
            $display("FAIL areset_pre: got dout=%h pd=%b low=%b err=%b want 5a 1 1 1",
                     dout, parity_done, low_pkt_valid, err); end
        // Assert reset between edges and check before the next rising edge.
        reset = 1'b1;
        #2;
        n_tests++;
        if ({dout, parity_done, low_pkt_valid, err} !== 11'd0) begin n_fail++;
            $display("FAIL areset_outputs: got dout=%h pd=%b low=%b err=%b want all 0",
                     dout, parity_done, low_pkt_valid, err); end
        n_tests++;
        if ({dut.hold_header, dut.full_byte, dut.internal_parity, dut.packet_parity} !== 32'd0) begin n_fail++;
            $display("FAIL areset_internal: got hh=%h fb=%h ip=%h pp=%h want 0",
                     dut.hold_header, dut.full_byte, dut.internal_parity, dut.packet_parity); end
        #1;
        reset = 1'b0;
        exp_q.delete();
        rows = '{mk(K_DA, 8'h05, 1, 0), mk(K_LFD, 8'h00, 1, 0)};
        foreach (rows[i]) begin
            drive(rows[i]); tick();
            if (emit) begin
                n_tests++;
                if (exp_q.size() == 0) begin n_fail++; $display("FAIL areset_next[%0d]: got %h, scoreboard empty", i, dout); end
                else begin e = exp_q.pop_front();
                    if (dout !== e) begin n_fail++; $display("FAIL areset_next[%0d]: got %h want %h", i, dout, e); end end
            end
        end
        n_tests++;
        if (dout !== 8'h05) begin n_fail++; $display("FAIL areset_header: got %h want 05", dout); end
    endtask

    // -----------------------------------------------------------------------
    initial begin
        reset = 1'b1;
        emit  = 1'b0;
        e     = '0;
        test_reset();
        test_good_packet();
        test_bad_parity();
        test_back_to_back();
        test_stall_payload();
        test_stall_parity();
        test_invalid_addr();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/router_reg.md
Name: router_reg

Overview:
Datapath register stage of the 1x3 router, sitting directly downstream of the router FSM and upstream of the three output FIFOs. It consumes the FSM state strobes and produces the byte written to the selected FIFO (dout). Around a FIFO-full stall it holds the header and parks one payload byte. It computes running packet parity, compares it with the received parity byte, and returns parity_done and low_pkt_valid to the FSM.

Parameters:
WIDTH, 8, data byte width (header, payload, parity, dout)

Ports:
clock  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-high reset
pkt_valid  input  1  source packet-valid; high for header and payload, low on the parity byte
data_in  input  WIDTH  source byte; header carries the destination address in bits [1:0]
fifo_full  input  1  full flag of the currently selected output FIFO
detect_add  input  1  FSM strobe: DECODE_ADDRESS state
lfd_state  input  1  FSM strobe: LOAD_FIRST_DATA state
ld_state  input  1  FSM strobe: LOAD_DATA state
full_state  input  1  FSM strobe: FIFO_FULL_STATE state
laf_state  input  1  FSM strobe: LOAD_AFTER_FULL state
rst_int_reg  input  1  FSM strobe: CHECK_PARITY_ERROR state
dout  output  WIDTH  byte presented to the output FIFOs (registered)
parity_done  output  1  parity byte captured, packet complete (registered)
low_pkt_valid  output  1  pkt_valid has fallen during LOAD_DATA (registered)
err  output  1  parity mismatch for the current packet (registered)

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high. Reset clears dout, parity_done, low_pkt_valid, err and all internal registers (hold_header, full_byte, internal_parity, packet_parity) to 0.
- hold_header: loads data_in when detect_add & pkt_valid & (data_in[1:0] != 2'b11); otherwise holds.
- dout priority, highest first:
  - lfd_state: dout <= hold_header.
  - ld_state & !fifo_full: dout <= data_in.
  - ld_state & fifo_full: full_byte <= data_in; dout holds.
  - laf_state: dout <= full_byte.
  - Otherwise dout holds.
- internal_parity:
  - detect_add: cleared to 0.
  - lfd_state: ^= hold_header.
  - ld_state & pkt_valid: ^= data_in, regardless of fifo_full. A parked byte is counted exactly once.
  - Otherwise holds.
- packet_parity: ld_state & !pkt_valid loads data_in, regardless of fifo_full. Cleared on detect_add.
- low_pkt_valid: rst_int_reg clears it (priority). ld_state & !pkt_valid sets it. Otherwise holds.
- parity_done:
  - detect_add clears it (priority).
  - Sets on (ld_state & !fifo_full & !pkt_valid), or on (laf_state & low_pkt_valid & !parity_done).
  - Otherwise holds.
- err:
  - lfd_state clears it (start of next packet).
  - Set one cycle after parity_done is high with internal_parity != packet_parity.
  - Holds through CHECK_PARITY_ERROR and DECODE_ADDRESS until the next lfd_state.
- Latency: data_in to dout is 1 cycle in LOAD_DATA. A parked byte appears on dout 1 cycle after laf_state is sampled.
- Boundary conditions:
  - full_state alone changes nothing; dout, full_byte and parity are frozen.
  - If fifo_full and !pkt_valid coincide in ld_state, the parity byte is parked in full_byte, low_pkt_valid is set, and parity_done waits for laf_state.
  - Header address 2'b11 is ignored; hold_header keeps its previous value.
  - Reset asserted mid-packet returns all state to 0 immediately, without waiting for a clock edge.
  - Back-to-back packets: detect_add clears the parity state; err persists until the next lfd_state.

Test Plan:
- Good packet, no stall: header 0x0D (addr 01, len 3), payload 0x11/0x22/0x33, parity 0x0D. Required: dout sequence 0x0D,0x11,0x22,0x33,0x0D; parity_done=1 the cycle after the parity byte; err stays 0; low_pkt_valid=1 until rst_int_reg.
- Bad parity: same packet with parity byte 0x00. Required: err=1 one cycle after parity_done; err held until the next lfd_state, then 0.
- Stall mid-payload: fifo_full=1 while ld_state carries 0x22. Required: dout holds 0x11; full_byte=0x22; after laf_state, dout=0x22; final internal_parity still 0x0D and err=0.
- Stall on parity byte: fifo_full=1 with ld_state & !pkt_valid on 0x0D. Required: low_pkt_valid=1, parity_done=0; parity_done=1 one cycle after laf_state; err=0.
- Asynchronous reset mid-payload: assert reset between clock edges. Required: dout, parity_done, low_pkt_valid, err all 0 before the next rising edge; next packet header 0x05 yields dout=0x05 on lfd_state.
- Invalid address: detect_add & pkt_valid with data_in=0x07. Required: hold_header unchanged (keeps 0x0D from the previous packet).
